fp_nr_divider_seq: RTL and testbench
====================================

// Module: fp_nr_divider_seq
// PURPOSE
//  Sequential IEEE-754 single-precision reciprocal/divider using Newton-Raphson refinement x' = x*(2 - d*x).
//  Reuses one registered FPU Multiplication and one Addition_Subtraction instance, stepped by an FSM.
//  Iteration count is a parameter. Mode selects 1/b or a/b. Has a valid/ready handshake on both sides.
//  Sits in the FPU beside the add/mul units; serves FDIV and reciprocal requests from the CPU execute stage.
// PARAMETERS
//  ITERATIONS  3             NR refinement passes, 1..7; each pass squares the relative error (seed err <= 1/17)
//  SEED_C1     32'h4034B4B5  48/17, constant term of the linear seed
//  SEED_C2     32'h3FF0F0F1  32/17, slope term of the linear seed
//  ENABLE_DIV  1             0: in_mode is ignored and treated as 0 (reciprocal only)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high
//  in_valid       in   1   request present
//  in_ready       out  1   block can accept a request (IDLE only)
//  in_mode        in   1   0: result = 1/in_b; 1: result = in_a/in_b
//  in_a           in   32  dividend (used only when in_mode=1)
//  in_b           in   32  divisor
//  out_valid      out  1   result valid; held until out_ready
//  out_ready      in   1   consumer accepts the result
//  out_result     out  32  IEEE-754 result
//  out_div_zero   out  1   finite nonzero numerator with divisor 0
//  out_invalid    out  1   NaN operand, 0/0, or inf/inf
//  out_overflow   out  1   result exponent >= 255; result saturated to signed inf
//  out_underflow  out  1   result exponent <= 0; result flushed to signed 0
//  busy           out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE. in_ready=1. out_valid=0. out_result=0. All flags 0. busy=0. Iteration counter=0.
//  Accept: a request is taken on the rising edge where in_valid && in_ready. Operands and mode are latched then.
//  Operand rules: denormal inputs are flushed to 0. Sign = a.sign^b.sign; in reciprocal mode sign = b.sign.
//  Normalise: d' = |b| with exponent forced to 126, so d' is in [0.5,1). Store eb = b.exp.
//  FSM. Each arithmetic state performs one FPU op and registers the result, so each state takes 1 cycle.
//   IDLE     -> SPECIAL if any special case applies, otherwise -> SEED_MUL
//   SEED_MUL t = SEED_C2*d'
//   SEED_SUB x = SEED_C1 - t
//   NR_MUL1  p = d'*x
//   NR_SUB   q = 2.0 - p
//   NR_MUL2  x = x*q; counter++; -> NR_MUL1 while counter < ITERATIONS, else -> SCALE
//   SCALE    r.exp = x.exp - (eb - 126), computed in signed 10 bits; apply sign, overflow/underflow saturation
//            -> FIN_MUL if mode=1, else -> DONE
//   FIN_MUL  r = |a|*r with sign applied; the multiplier's overflow/underflow map to the flags -> DONE
//   SPECIAL  load the special result and its flags -> DONE
//   DONE     out_valid=1. Stay while !out_ready. On out_ready: out_valid=0, -> IDLE
//  Special cases, in priority order:
//   - a or b is NaN -> 7FC00000, invalid
//   - 0/0 or inf/inf -> 7FC00000, invalid
//   - b = 0 -> signed inf, div_zero (1/0 also sets div_zero)
//   - b = inf -> signed 0
//   - a = 0 -> signed 0
//   - a = inf -> signed inf
//  Latency from accept edge to out_valid rising:
//   reciprocal: 3 + 3*ITERATIONS cycles (12 at the default)
//   divide: 4 + 3*ITERATIONS cycles (13 at the default)
//   special case: 2 cycles
//  Accuracy: |result - exact| <= 2 ulp for normal results when ITERATIONS >= 3.
//  out_result and the flags are stable for as long as out_valid=1. Flags update only when entering DONE.
//  in_ready=0 in every state except IDLE. There is no overlap; a new accept is possible the cycle after the DONE handshake.
//  Reset mid-operation: outputs return to reset values asynchronously. The in-flight request is discarded with no output.
// TESTING
//  1. mode0, b=40800000 (4.0) -> 3E800000 +/-2ulp, out_valid exactly 12 cycles after accept.
//  2. mode1, a=40C00000 (6.0), b=40400000 (3.0) -> 40000000 +/-2ulp at 13 cycles. Repeat with b=C0400000 -> C0000000.
//  3. mode1, a=3F800000, b=00000000 -> 7F800000, div_zero=1, 2 cycles. mode1 a=b=0 -> 7FC00000, invalid=1.
//  4. mode1, a=7F000000, b=3E800000 -> 7F800000, overflow=1. mode0, b=7F7FFFFF -> 0, underflow=1.
//  5. Backpressure: hold out_ready=0 for 5 cycles at DONE -> result stable, in_ready=0, a second in_valid is not accepted.
//  6. Assert reset at cycle 6 of a divide -> out_valid=0, in_ready=1. The next request (1/2.0) -> 3F000000.

Source files
------------

// File: rtl/fp_nr_divider_seq.sv
// Sequential single-precision reciprocal/divider: linear seed, Newton-Raphson x' = x*(2 - d*x),
// one shared registered multiply and one shared subtract, stepped by a two-process FSM.
module fp_nr_divider_seq #(
  parameter int unsigned ITERATIONS = 3,
  parameter logic [31:0] SEED_C1    = 32'h4034B4B5,
  parameter logic [31:0] SEED_C2    = 32'h3FF0F0F1,
  parameter bit          ENABLE_DIV = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_div_zero,
  output logic        out_invalid,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        busy
);
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] TWO  = 32'h40000000;

  typedef enum logic [3:0] {
    S_IDLE, S_SEED_MUL, S_SEED_SUB, S_NR_MUL1, S_NR_SUB, S_NR_MUL2,
    S_SCALE, S_FIN_MUL, S_SPECIAL, S_DONE
  } state_t;

  // Positive-operand multiply, round half up; returns {overflow, underflow, result}.
  function automatic logic [33:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0]        prod;
    logic signed [9:0]  e;
    logic [24:0]        m;
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 34'd0;
    prod = {1'b1, x[22:0]} * {1'b1, y[22:0]};
    e    = 10'(x[30:23]) + 10'(y[30:23]) - 10'd127;
    if (prod[47]) begin
      m = {1'b0, prod[47:24]} + 25'(prod[23]);
      e = e + 10'sd1;
    end else begin
      m = {1'b0, prod[46:23]} + 25'(prod[22]);
    end
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {2'b10, 1'b0, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {2'b01, 32'd0};
    return {2'b00, 1'b0, e[7:0], m[22:0]};
  endfunction

  // Positive subtract x - y, valid for x >= y > 0 (true for every use in the NR loop).
  function automatic logic [31:0] fp_sub(input logic [31:0] x, input logic [31:0] y);
    logic [49:0]       mx, my, df;
    logic [7:0]        sh;
    logic [5:0]        lz;
    logic signed [9:0] e;
    logic [24:0]       m;
    sh = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 26'd0};
    my = (sh > 8'd49) ? 50'd0 : ({1'b1, y[22:0], 26'd0} >> sh);
    df = mx - my;
    if (df == 50'd0) return 32'd0;
    lz = 6'd0;
    for (int i = 0; i < 50; i++) if (df[i]) lz = 6'(49 - i);
    df = df << lz;
    m  = {1'b0, df[49:26]} + 25'(df[25]);
    e  = 10'(x[30:23]) - 10'(lz);
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e <= 10'sd0) return 32'd0;
    return {1'b0, e[7:0], m[22:0]};
  endfunction

  state_t            state, state_n;
  logic [2:0]        cnt;
  logic [31:0]       a_reg, d_reg, x_reg, tmp_reg, res_reg;
  logic [7:0]        eb_reg;
  logic              sign_reg, mode_reg, dz_reg, inv_reg, ov_reg, un_reg;

  logic              mode_eff, sign_in, za, zb, ia, ib, na, nb;
  logic [31:0]       a_f, b_f, a_eff;
  logic              sp_hit, sp_inv, sp_dz;
  logic [31:0]       sp_res;
  logic [31:0]       mul_x, mul_y, sub_x, sub_y, sub_out;
  logic [33:0]       mul_out;
  logic signed [9:0] se;
  logic              scl_ov, scl_un, fin_ov, fin_un;
  logic [31:0]       scl_res, fin_res;

  // Operand conditioning and special-case classification at the accept edge.
  always_comb begin
    mode_eff = ENABLE_DIV && in_mode;
    a_f      = (in_a[30:23] == 8'd0) ? {in_a[31], 31'd0} : in_a;
    b_f      = (in_b[30:23] == 8'd0) ? {in_b[31], 31'd0} : in_b;
    a_eff    = mode_eff ? a_f : ONE;
    sign_in  = a_eff[31] ^ b_f[31];
    za = (a_eff[30:23] == 8'd0);
    zb = (b_f[30:23] == 8'd0);
    ia = (a_eff[30:23] == 8'hFF) && (a_eff[22:0] == 23'd0);
    ib = (b_f[30:23] == 8'hFF) && (b_f[22:0] == 23'd0);
    na = (a_eff[30:23] == 8'hFF) && (a_eff[22:0] != 23'd0);
    nb = (b_f[30:23] == 8'hFF) && (b_f[22:0] != 23'd0);
    sp_hit = 1'b1;
    sp_res = 32'd0;
    sp_inv = 1'b0;
    sp_dz  = 1'b0;
    if (na || nb) begin
      sp_res = QNAN;
      sp_inv = 1'b1;
    end else if ((za && zb) || (ia && ib)) begin
      sp_res = QNAN;
      sp_inv = 1'b1;
    end else if (zb) begin
      sp_res = {sign_in, 8'hFF, 23'd0};
      sp_dz  = 1'b1;
    end else if (ib || za) begin
      sp_res = {sign_in, 31'd0};
    end else if (ia) begin
      sp_res = {sign_in, 8'hFF, 23'd0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // Shared arithmetic units with per-state operand selection.
  always_comb begin
    mul_x = a_reg;
    mul_y = {1'b0, res_reg[30:0]};
    sub_x = TWO;
    sub_y = tmp_reg;
    case (state)
      S_SEED_MUL: begin mul_x = SEED_C2; mul_y = d_reg;   end
      S_NR_MUL1:  begin mul_x = d_reg;   mul_y = x_reg;   end
      S_NR_MUL2:  begin mul_x = x_reg;   mul_y = tmp_reg; end
      default: ;
    endcase
    if (state == S_SEED_SUB) sub_x = SEED_C1;
    mul_out = fp_mul(mul_x, mul_y);
    sub_out = fp_sub(sub_x, sub_y);
  end

  // Undo the divisor normalisation and pick the value loaded into the outputs on entering DONE.
  always_comb begin
    se      = 10'(x_reg[30:23]) - 10'(eb_reg) + 10'sd126;
    scl_ov  = (se >= 10'sd255);
    scl_un  = (se <= 10'sd0);
    scl_res = scl_ov ? {sign_reg, 8'hFF, 23'd0} :
              scl_un ? {sign_reg, 31'd0} : {sign_reg, se[7:0], x_reg[22:0]};
    fin_res = res_reg;
    fin_ov  = ov_reg;
    fin_un  = un_reg;
    if (state == S_SCALE) begin
      fin_res = scl_res;
      fin_ov  = scl_ov;
      fin_un  = scl_un;
    end else if (state == S_FIN_MUL) begin
      fin_res = {sign_reg, mul_out[30:0]};
      fin_ov  = ov_reg | mul_out[33];
      fin_un  = un_reg | mul_out[32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // SPECIAL is held two cycles so special results keep a fixed 2-cycle latency.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (in_valid) state_n = sp_hit ? S_SPECIAL : S_SEED_MUL;
      S_SEED_MUL: state_n = S_SEED_SUB;
      S_SEED_SUB: state_n = S_NR_MUL1;
      S_NR_MUL1:  state_n = S_NR_SUB;
      S_NR_SUB:   state_n = S_NR_MUL2;
      S_NR_MUL2:  state_n = (32'(cnt) + 32'd1 < ITERATIONS) ? S_NR_MUL1 : S_SCALE;
      S_SCALE:    state_n = mode_reg ? S_FIN_MUL : S_DONE;
      S_FIN_MUL:  state_n = S_DONE;
      S_SPECIAL:  state_n = (cnt != 3'd0) ? S_DONE : S_SPECIAL;
      S_DONE:     if (out_ready) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 3'd0; a_reg <= 32'd0; d_reg <= 32'd0; x_reg <= 32'd0; tmp_reg <= 32'd0;
      res_reg <= 32'd0; eb_reg <= 8'd0; sign_reg <= 1'b0; mode_reg <= 1'b0;
      dz_reg <= 1'b0; inv_reg <= 1'b0; ov_reg <= 1'b0; un_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_reg <= {1'b0, a_eff[30:0]};
          d_reg <= {1'b0, 8'd126, b_f[22:0]};
          eb_reg <= b_f[30:23];
          sign_reg <= sign_in;
          mode_reg <= mode_eff;
          cnt <= 3'd0;
          res_reg <= sp_res;
          inv_reg <= sp_inv;
          dz_reg <= sp_dz;
          ov_reg <= 1'b0;
          un_reg <= 1'b0;
        end
        S_SEED_MUL, S_NR_MUL1: tmp_reg <= mul_out[31:0];
        S_SEED_SUB: x_reg <= sub_out;
        S_NR_SUB:   tmp_reg <= sub_out;
        S_NR_MUL2: begin
          x_reg <= mul_out[31:0];
          cnt   <= cnt + 3'd1;
        end
        S_SCALE: begin
          res_reg <= scl_res;
          ov_reg  <= scl_ov;
          un_reg  <= scl_un;
        end
        S_SPECIAL: cnt <= cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Registered handshake/status; result and flags load only on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready <= 1'b1; out_valid <= 1'b0; busy <= 1'b0; out_result <= 32'd0;
      out_div_zero <= 1'b0; out_invalid <= 1'b0; out_overflow <= 1'b0; out_underflow <= 1'b0;
    end else begin
      in_ready  <= (state_n == S_IDLE);
      out_valid <= (state_n == S_DONE);
      busy      <= (state_n != S_IDLE);
      if (state_n == S_DONE && state != S_DONE) begin
        out_result    <= fin_res;
        out_div_zero  <= dz_reg;
        out_invalid   <= inv_reg;
        out_overflow  <= fin_ov;
        out_underflow <= fin_un;
      end
    end
  end
endmodule

// File: tb/tb_fp_nr_divider_seq.sv
// Directed bench for fp_nr_divider_seq: latency, accuracy, special cases, saturation,
// backpressure and mid-operation reset.
module tb_fp_nr_divider_seq;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, out_result;
  logic        out_div_zero, out_invalid, out_overflow, out_underflow;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fp_nr_divider_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_div_zero(out_div_zero), .out_invalid(out_invalid),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .busy(busy)
  );

  // Issue one request; lat = cycles from accept edge to out_valid, -1 on timeout.
  task automatic run_req(input logic mode, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_mode = mode; in_a = a; in_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_err++; $display("FAIL rst_result got %h want 00000000", out_result); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++;
    if ({out_div_zero, out_invalid, out_overflow, out_underflow} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_flags got %b%b%b%b want 0000", out_div_zero, out_invalid, out_overflow, out_underflow);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_recip();
    int lat;
    longint d;
    run_req(1'b0, 32'hDEADBEEF, 32'h40800000, lat);
    n_cmp++; if (lat !== 12) begin n_err++; $display("FAIL recip_latency got %0d want 12", lat); end
    d = longint'(out_result) - longint'(32'h3E800000);
    if (d < 0) d = -d;
    n_cmp++; if (d > 2) begin n_err++; $display("FAIL recip_4 got %h want 3e800000 +/-2ulp", out_result); end
    n_cmp++;
    if ({out_div_zero, out_invalid, out_overflow, out_underflow} !== 4'b0) begin
      n_err++; $display("FAIL recip_flags got %b%b%b%b want 0000", out_div_zero, out_invalid, out_overflow, out_underflow);
    end
    ack();
  endtask

  task automatic test_divide();
    logic [31:0] tb_b[2];
    logic [31:0] tb_e[2];
    int lat;
    longint d;
    tb_b[0] = 32'h40400000; tb_e[0] = 32'h40000000;
    tb_b[1] = 32'hC0400000; tb_e[1] = 32'hC0000000;
    for (int i = 0; i < 2; i++) begin
      run_req(1'b1, 32'h40C00000, tb_b[i], lat);
      n_cmp++; if (lat !== 13) begin n_err++; $display("FAIL div_latency[%0d] got %0d want 13", i, lat); end
      d = longint'(out_result) - longint'(tb_e[i]);
      if (d < 0) d = -d;
      n_cmp++; if (d > 2) begin n_err++; $display("FAIL div_result[%0d] got %h want %h +/-2ulp", i, out_result, tb_e[i]); end
      ack();
    end
  endtask

  task automatic test_special();
    logic        tm[5];
    logic [31:0] ta[5], tbv[5], te[5];
    logic        tdz[5], tinv[5];
    int lat;
    tm[0] = 1; ta[0] = 32'h3F800000; tbv[0] = 32'h00000000; te[0] = 32'h7F800000; tdz[0] = 1; tinv[0] = 0;
    tm[1] = 1; ta[1] = 32'h00000000; tbv[1] = 32'h00000000; te[1] = 32'h7FC00000; tdz[1] = 0; tinv[1] = 1;
    tm[2] = 0; ta[2] = 32'h12345678; tbv[2] = 32'hFF800000; te[2] = 32'h80000000; tdz[2] = 0; tinv[2] = 0;
    tm[3] = 1; ta[3] = 32'h7F800001; tbv[3] = 32'h40000000; te[3] = 32'h7FC00000; tdz[3] = 0; tinv[3] = 1;
    tm[4] = 0; ta[4] = 32'h00000000; tbv[4] = 32'h80000000; te[4] = 32'hFF800000; tdz[4] = 1; tinv[4] = 0;
    for (int i = 0; i < 5; i++) begin
      run_req(tm[i], ta[i], tbv[i], lat);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL spec_latency[%0d] got %0d want 2", i, lat); end
      n_cmp++; if (out_result !== te[i]) begin n_err++; $display("FAIL spec_result[%0d] got %h want %h", i, out_result, te[i]); end
      n_cmp++; if (out_div_zero !== tdz[i]) begin n_err++; $display("FAIL spec_dz[%0d] got %b want %b", i, out_div_zero, tdz[i]); end
      n_cmp++; if (out_invalid !== tinv[i]) begin n_err++; $display("FAIL spec_inv[%0d] got %b want %b", i, out_invalid, tinv[i]); end
      ack();
    end
  endtask

  task automatic test_ovf_unf();
    int lat;
    run_req(1'b1, 32'h7F000000, 32'h3E800000, lat);
    n_cmp++; if (out_result !== 32'h7F800000) begin n_err++; $display("FAIL ovf_result got %h want 7f800000", out_result); end
    n_cmp++; if (out_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", out_overflow); end
    ack();
    run_req(1'b0, 32'h0, 32'h7F7FFFFF, lat);
    n_cmp++; if (out_result !== 32'h00000000) begin n_err++; $display("FAIL unf_result got %h want 00000000", out_result); end
    n_cmp++; if (out_underflow !== 1'b1) begin n_err++; $display("FAIL unf_flag got %b want 1", out_underflow); end
    ack();
  endtask

  task automatic test_back_to_back();
    int lat;
    longint d;
    run_req(1'b1, 32'h40C00000, 32'h40400000, lat);
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_b = 32'h40800000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      d = longint'(out_result) - longint'(32'h40000000);
      if (d < 0) d = -d;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b want 1", c, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); end
      n_cmp++; if (d > 2) begin n_err++; $display("FAIL bp_result[%0d] got %h want 40000000 +/-2ulp", c, out_result); end
    end
    in_valid = 1'b0;
    ack();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midop();
    int lat;
    longint d;
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b1; in_a = 32'h40C00000; in_b = 32'h40400000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    run_req(1'b0, 32'h0, 32'h40000000, lat);
    n_cmp++; if (lat !== 12) begin n_err++; $display("FAIL midrst_latency got %0d want 12", lat); end
    d = longint'(out_result) - longint'(32'h3F000000);
    if (d < 0) d = -d;
    n_cmp++; if (d > 2) begin n_err++; $display("FAIL midrst_result got %h want 3f000000 +/-2ulp", out_result); end
    ack();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_a = 32'h0; in_b = 32'h0; out_ready = 1'b0;
    test_reset();
    test_recip();
    test_divide();
    test_special();
    test_ovf_unf();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
